// File: rtl/fetch_stage.sv
// Instruction-fetch stage: registers the selected PC, drives synchronous-read
// BIOS/IMEM addresses a cycle ahead, and presents the aligned instruction to ID.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013,
    parameter int unsigned BIOS_AW  = 12,
    parameter int unsigned IMEM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        next_pc,
    input  logic               stall,
    input  logic               flush,
    output logic [31:0]        pc_plus4,
    output logic [BIOS_AW-1:0] bios_addr,
    input  logic [31:0]        bios_dout,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_dout,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_inst,
    output logic               if_valid,
    output logic               fetch_fault,
    output logic [31:0]        fetch_cnt
);

    logic [31:0] pc_q;
    logic        live_q;
    logic        fault_q;
    logic [31:0] cnt_q;

    logic [31:0] fa;
    logic [31:0] data;
    logic        bad;
    logic        ok;

    // Fetch address: reset first, then flush redirect (beats stall), then hold on stall.
    always_comb begin
        fa = next_pc;
        if (rst) begin
            fa = RESET_PC;
        end else if (flush) begin
            fa = next_pc;
        end else if (stall) begin
            fa = pc_q;
        end
    end

    // Both memories always see the fetch address; region choice happens on the data side.
    assign bios_addr = fa[BIOS_AW+1:2];
    assign imem_addr = fa[IMEM_AW+1:2];

    // Region decode of the registered PC selects which memory's data is live.
    always_comb begin
        bad  = 1'b0;
        data = NOP;
        case (pc_q[31:28])
            4'b0100: data = bios_dout;
            4'b0001: data = imem_dout;
            default: bad  = 1'b1;
        endcase
        if (pc_q[1:0] != 2'b00) begin
            bad = 1'b1;
        end
    end

    assign ok          = live_q & ~flush & ~bad;
    assign if_pc       = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign if_valid    = ok;
    assign if_inst     = ok ? data : NOP;
    assign fetch_fault = fault_q;
    assign fetch_cnt   = cnt_q;

    // PC register, liveness, sticky fault flag and delivered-instruction counter.
    always_ff @(posedge clk) begin
        pc_q   <= fa;
        live_q <= ~rst;
        if (rst) begin
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (live_q & ~flush & bad & ~stall) begin
                fault_q <= 1'b1;
            end
            if (ok & ~stall) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: sync-read memory models plus a PC scoreboard.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h4000_0000;
    localparam logic [31:0] NOP_I    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] next_pc;
    logic        stall;
    logic        flush;
    logic [31:0] pc_plus4;
    logic [11:0] bios_addr;
    logic [31:0] bios_dout;
    logic [13:0] imem_addr;
    logic [31:0] imem_dout;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        fetch_fault;
    logic [31:0] fetch_cnt;

    int unsigned checks = 0;
    int unsigned passes = 0;

    logic [31:0] pc_sb[$];
    logic [31:0] m_pc;
    logic        m_live;
    logic        m_fault;
    logic [31:0] m_cnt;

    fetch_stage #(
        .RESET_PC(RESET_PC),
        .NOP     (NOP_I),
        .BIOS_AW (12),
        .IMEM_AW (14)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .next_pc    (next_pc),
        .stall      (stall),
        .flush      (flush),
        .pc_plus4   (pc_plus4),
        .bios_addr  (bios_addr),
        .bios_dout  (bios_dout),
        .imem_addr  (imem_addr),
        .imem_dout  (imem_dout),
        .if_pc      (if_pc),
        .if_inst    (if_inst),
        .if_valid   (if_valid),
        .fetch_fault(fetch_fault),
        .fetch_cnt  (fetch_cnt)
    );

    function automatic logic [31:0] bios_word(input logic [11:0] a);
        return 32'hB105_0000 ^ {20'd0, a};
    endfunction

    function automatic logic [31:0] imem_word(input logic [13:0] a);
        return 32'h1EE0_0000 ^ {18'd0, a};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read memories: one cycle from address to data.
    always @(posedge clk) begin
        bios_dout <= bios_word(bios_addr);
        imem_dout <= imem_word(imem_addr);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end

    // Drive one cycle, compare all outputs against the scoreboard entry, update the model.
    task automatic run_cycle(input logic r, input logic [31:0] np, input logic s, input logic f);
        logic [31:0] exp_pc;
        logic [31:0] fa;
        logic [31:0] data;
        logic [31:0] exp_inst;
        logic        bad;
        logic        ok;
        bad = 1'b1;
        ok  = 1'b0;
        @(negedge clk);
        rst = r; next_pc = np; stall = s; flush = f;
        #1;
        fa = r ? RESET_PC : (f ? np : (s ? m_pc : np));
        checks++;
        if (bios_addr !== fa[13:2]) $display("FAIL bios_addr got %h want %h", bios_addr, fa[13:2]);
        else passes++;
        checks++;
        if (imem_addr !== fa[15:2]) $display("FAIL imem_addr got %h want %h", imem_addr, fa[15:2]);
        else passes++;
        checks++;
        if (fetch_fault !== m_fault) $display("FAIL fetch_fault got %b want %b", fetch_fault, m_fault);
        else passes++;
        checks++;
        if (fetch_cnt !== m_cnt) $display("FAIL fetch_cnt got %0d want %0d", fetch_cnt, m_cnt);
        else passes++;
        checks++;
        if (pc_sb.size() == 0) begin
            $display("FAIL scoreboard got empty want entry");
        end else begin
            passes++;
            exp_pc = pc_sb.pop_front();
            bad = !((exp_pc[31:28] == 4'h4) || (exp_pc[31:28] == 4'h1)) || (exp_pc[1:0] != 2'b00);
            data = (exp_pc[31:28] == 4'h4) ? bios_word(exp_pc[13:2]) : imem_word(exp_pc[15:2]);
            ok = m_live && !f && !bad;
            exp_inst = ok ? data : NOP_I;
            checks++;
            if (if_pc !== exp_pc) $display("FAIL if_pc got %h want %h", if_pc, exp_pc);
            else passes++;
            checks++;
            if (pc_plus4 !== exp_pc + 32'd4) $display("FAIL pc_plus4 got %h want %h", pc_plus4, exp_pc + 32'd4);
            else passes++;
            checks++;
            if (if_valid !== ok) $display("FAIL if_valid got %b want %b (pc %h)", if_valid, ok, exp_pc);
            else passes++;
            checks++;
            if (if_inst !== exp_inst) $display("FAIL if_inst got %h want %h (pc %h)", if_inst, exp_inst, exp_pc);
            else passes++;
        end
        if (r) begin
            m_live = 1'b0; m_fault = 1'b0; m_cnt = '0;
        end else begin
            if (m_live && !f && bad && !s) m_fault = 1'b1;
            if (ok && !s) m_cnt = m_cnt + 32'd1;
            m_live = 1'b1;
        end
        m_pc = fa;
        pc_sb.push_back(fa);
    endtask

    task automatic test_reset();
        run_cycle(1'b1, 32'h1000_0000, 1'b0, 1'b0);
        run_cycle(1'b1, 32'h1000_0000, 1'b1, 1'b0);
        checks++;
        if (if_valid !== 1'b0 || if_pc !== RESET_PC || fetch_cnt !== 32'd0 || pc_plus4 !== 32'h4000_0004)
            $display("FAIL reset_state got pc %h valid %b cnt %0d p4 %h want pc %h valid 0 cnt 0 p4 40000004",
                     if_pc, if_valid, fetch_cnt, pc_plus4, RESET_PC);
        else passes++;
    endtask

    task automatic test_sequential();
        run_cycle(1'b0, RESET_PC, 1'b0, 1'b0);
        run_cycle(1'b0, 32'h4000_0004, 1'b0, 1'b0);
        checks++;
        if (if_pc !== 32'h4000_0000 || if_valid !== 1'b1 || if_inst !== bios_word(12'h000))
            $display("FAIL first_fetch got pc %h valid %b inst %h want pc 40000000 valid 1 inst %h",
                     if_pc, if_valid, if_inst, bios_word(12'h000));
        else passes++;
        run_cycle(1'b0, 32'h4000_0008, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        logic [31:0] held;
        held = bios_word(12'h002);
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, 32'h1234_5670, 1'b1, 1'b0);
            checks++;
            if (if_pc !== 32'h4000_0008 || bios_addr !== 12'h002 || if_inst !== held || fetch_cnt !== 32'd2)
                $display("FAIL stall_hold got pc %h baddr %h inst %h cnt %0d want pc 40000008 baddr 002 inst %h cnt 2",
                         if_pc, bios_addr, if_inst, fetch_cnt, held);
            else passes++;
        end
        run_cycle(1'b0, 32'h4000_000C, 1'b0, 1'b0);
        run_cycle(1'b0, 32'h4000_0010, 1'b0, 1'b0);
        checks++;
        if (if_pc !== 32'h4000_000C || fetch_cnt !== 32'd3)
            $display("FAIL stall_resume got pc %h cnt %0d want pc 4000000c cnt 3", if_pc, fetch_cnt);
        else passes++;
    endtask

    task automatic test_flush();
        run_cycle(1'b0, 32'h1000_0020, 1'b0, 1'b1);
        checks++;
        if (if_valid !== 1'b0 || if_inst !== NOP_I || imem_addr !== 14'h0008)
            $display("FAIL flush_kill got valid %b inst %h iaddr %h want valid 0 inst 00000013 iaddr 0008",
                     if_valid, if_inst, imem_addr);
        else passes++;
        run_cycle(1'b0, 32'h1000_0024, 1'b0, 1'b0);
        checks++;
        if (if_pc !== 32'h1000_0020 || if_inst !== imem_word(14'h0008) || if_valid !== 1'b1)
            $display("FAIL flush_target got pc %h inst %h valid %b want pc 10000020 inst %h valid 1",
                     if_pc, if_inst, if_valid, imem_word(14'h0008));
        else passes++;
    endtask

    task automatic test_stall_flush();
        run_cycle(1'b0, 32'h1000_0040, 1'b1, 1'b1);
        run_cycle(1'b0, 32'h1000_0044, 1'b0, 1'b0);
        checks++;
        if (if_pc !== 32'h1000_0040 || if_valid !== 1'b1)
            $display("FAIL stall_flush got pc %h valid %b want pc 10000040 valid 1", if_pc, if_valid);
        else passes++;
    endtask

    task automatic test_bad_region();
        run_cycle(1'b0, 32'h4000_0002, 1'b0, 1'b0);
        run_cycle(1'b0, 32'h1000_0010, 1'b0, 1'b1);
        run_cycle(1'b0, 32'h2000_0000, 1'b0, 1'b0);
        checks++;
        if (fetch_fault !== 1'b0)
            $display("FAIL flushed_bad_no_fault got %b want 0", fetch_fault);
        else passes++;
        run_cycle(1'b0, 32'h1000_0000, 1'b0, 1'b0);
        checks++;
        if (if_valid !== 1'b0 || if_inst !== NOP_I)
            $display("FAIL bad_region_nop got valid %b inst %h want valid 0 inst 00000013", if_valid, if_inst);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, 32'h1000_0004 + 32'(4 * i), 1'b0, 1'b0);
            checks++;
            if (fetch_fault !== 1'b1)
                $display("FAIL fault_sticky got %b want 1", fetch_fault);
            else passes++;
        end
    endtask

    task automatic test_random();
        logic [31:0] np;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0, 1: np = 32'h4000_0000 + {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
                2, 3: np = 32'h1000_0000 + {16'd0, 14'($urandom_range(0, 16383)), 2'b00};
                4:    np = 32'h4000_0001;
                default: np = 32'h0000_1000;
            endcase
            run_cycle(1'b0, np, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
        end
    endtask

    task automatic test_reset_mid_stall();
        run_cycle(1'b0, 32'h1000_0010, 1'b0, 1'b1);
        run_cycle(1'b0, 32'h1000_0014, 1'b1, 1'b0);
        run_cycle(1'b1, 32'h1000_0050, 1'b1, 1'b0);
        run_cycle(1'b0, RESET_PC, 1'b0, 1'b0);
        checks++;
        if (if_pc !== RESET_PC || if_valid !== 1'b0 || fetch_cnt !== 32'd0 || fetch_fault !== 1'b0)
            $display("FAIL reset_mid_stall got pc %h valid %b cnt %0d fault %b want pc 40000000 valid 0 cnt 0 fault 0",
                     if_pc, if_valid, fetch_cnt, fetch_fault);
        else passes++;
        run_cycle(1'b1, 32'h1000_0020, 1'b0, 1'b1);
        run_cycle(1'b0, RESET_PC, 1'b0, 1'b0);
        checks++;
        if (if_pc !== RESET_PC || if_valid !== 1'b0)
            $display("FAIL reset_mid_flush got pc %h valid %b want pc 40000000 valid 0", if_pc, if_valid);
        else passes++;
        run_cycle(1'b0, 32'h4000_0004, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; next_pc = '0; stall = 1'b0; flush = 1'b0;
        @(posedge clk);
        m_pc = RESET_PC; m_live = 1'b0; m_fault = 1'b0; m_cnt = '0;
        pc_sb.push_back(RESET_PC);
        test_reset();
        test_sequential();
        test_stall();
        test_flush();
        test_stall_flush();
        test_bad_region();
        test_random();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
